// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_pkg
// Description : Shared encodings for the multicycle ARM controller: FSM state
//               codes, ALU / mux select codes, instruction Op, Cond and cmd
//               codes, plus small cmd-decode helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

   // FSM state codes; codes 10..15 are illegal and recover to FETCH.
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   // ALUControl codes
   localparam logic [1:0] c_ALU_ADD = 2'b00;
   localparam logic [1:0] c_ALU_SUB = 2'b01;
   localparam logic [1:0] c_ALU_AND = 2'b10;
   localparam logic [1:0] c_ALU_ORR = 2'b11;

   // ResultSrc codes
   localparam logic [1:0] c_RES_ALUOUT = 2'b00;
   localparam logic [1:0] c_RES_DATA   = 2'b01;
   localparam logic [1:0] c_RES_ALU    = 2'b10;

   // ALUSrcB codes
   localparam logic [1:0] c_SRCB_REG  = 2'b00;
   localparam logic [1:0] c_SRCB_IMM  = 2'b01;
   localparam logic [1:0] c_SRCB_FOUR = 2'b10;

   // Instruction Op field
   localparam logic [1:0] c_OP_DP  = 2'b00;
   localparam logic [1:0] c_OP_MEM = 2'b01;
   localparam logic [1:0] c_OP_BR  = 2'b10;
   localparam logic [1:0] c_OP_NOP = 2'b11;

   // Condition codes
   localparam logic [3:0] c_COND_EQ = 4'b0000;
   localparam logic [3:0] c_COND_NE = 4'b0001;
   localparam logic [3:0] c_COND_CS = 4'b0010;
   localparam logic [3:0] c_COND_CC = 4'b0011;
   localparam logic [3:0] c_COND_MI = 4'b0100;
   localparam logic [3:0] c_COND_PL = 4'b0101;
   localparam logic [3:0] c_COND_VS = 4'b0110;
   localparam logic [3:0] c_COND_VC = 4'b0111;
   localparam logic [3:0] c_COND_HI = 4'b1000;
   localparam logic [3:0] c_COND_LS = 4'b1001;
   localparam logic [3:0] c_COND_GE = 4'b1010;
   localparam logic [3:0] c_COND_LT = 4'b1011;
   localparam logic [3:0] c_COND_GT = 4'b1100;
   localparam logic [3:0] c_COND_LE = 4'b1101;
   localparam logic [3:0] c_COND_AL = 4'b1110;

   // Data-processing cmd field (Funct[4:1])
   localparam logic [3:0] c_CMD_ADD = 4'b0100;
   localparam logic [3:0] c_CMD_SUB = 4'b0010;
   localparam logic [3:0] c_CMD_AND = 4'b0000;
   localparam logic [3:0] c_CMD_ORR = 4'b1100;
   localparam logic [3:0] c_CMD_CMP = 4'b1010;

   // ALU operation for a data-processing cmd; unsupported cmds fall back to ADD.
   function automatic logic [1:0] aluOp(input logic [3:0] cmd);
      logic [1:0] op;
      case (cmd)
         c_CMD_ADD: op = c_ALU_ADD;
         c_CMD_SUB: op = c_ALU_SUB;
         c_CMD_CMP: op = c_ALU_SUB;
         c_CMD_AND: op = c_ALU_AND;
         c_CMD_ORR: op = c_ALU_ORR;
         default:   op = c_ALU_ADD;
      endcase
      return op;
   endfunction

   // Only the four arithmetic/logic cmds write the register file.
   function automatic logic cmdWritesReg(input logic [3:0] cmd);
      return (cmd == c_CMD_ADD) || (cmd == c_CMD_SUB) ||
             (cmd == c_CMD_AND) || (cmd == c_CMD_ORR);
   endfunction

   // Supported cmds (including CMP) may update flags; unknown cmds never do.
   function automatic logic cmdWritesFlags(input logic [3:0] cmd);
      return cmdWritesReg(cmd) || (cmd == c_CMD_CMP);
   endfunction

   // Carry/overflow are meaningful only for the adder-based cmds.
   function automatic logic cmdWritesCV(input logic [3:0] cmd);
      return (cmd == c_CMD_ADD) || (cmd == c_CMD_SUB) || (cmd == c_CMD_CMP);
   endfunction

endpackage : multicycle_controller_pkg
`default_nettype wire

// File: rtl/multicycle_controller_cond_flag_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_flag_unit
// Description : Architectural NZCV register and condition evaluation. The
//               condition result is latched once per instruction (in DECODE)
//               and then gates every write for the rest of the instruction.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               Cond            - instruction condition field
//               ALUFlags        - ALU {N,Z,C,V} of the current cycle
//               latchCond       - capture CondEx(Cond, Flags) this cycle
//               execCycle       - controller is in EXECR/EXECI
//               sBit            - instruction S bit (Funct[0])
//               cmd             - data-processing cmd (Funct[4:1])
//               Flags           - registered NZCV
//               condQ           - latched condition result
// Revision    : 1.0 - initial release
// ============================================================================
module cond_flag_unit
   import multicycle_controller_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic       latchCond,
   input  logic       execCycle,
   input  logic       sBit,
   input  logic [3:0] cmd,
   output logic [3:0] Flags,
   output logic       condQ
);

   logic [3:0] r_flags;
   logic       r_condQ;
   logic       w_condEx;
   logic       w_flagWrite;
   logic       w_cvWrite;

   // Condition evaluation against the registered flags only.
   function automatic logic condEx(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, res;
      {n, z, c, v} = nzcv;
      case (cond)
         c_COND_EQ: res = z;
         c_COND_NE: res = ~z;
         c_COND_CS: res = c;
         c_COND_CC: res = ~c;
         c_COND_MI: res = n;
         c_COND_PL: res = ~n;
         c_COND_VS: res = v;
         c_COND_VC: res = ~v;
         c_COND_HI: res = c & ~z;
         c_COND_LS: res = ~c | z;
         c_COND_GE: res = (n == v);
         c_COND_LT: res = (n != v);
         c_COND_GT: res = ~z & (n == v);
         c_COND_LE: res = z | (n != v);
         default:   res = 1'b1;   // AL and the unconditional 1111 space
      endcase
      return res;
   endfunction

   assign w_condEx    = condEx(Cond, r_flags);
   assign w_flagWrite = execCycle & sBit & r_condQ & cmdWritesFlags(cmd);
   assign w_cvWrite   = cmdWritesCV(cmd);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_flags <= RESET_FLAGS;
         r_condQ <= 1'b0;
      end else begin
         if (latchCond) begin
            r_condQ <= w_condEx;
         end
         if (w_flagWrite) begin
            r_flags[3:2] <= ALUFlags[3:2];
            // Logical ops leave C and V untouched.
            if (w_cvWrite) begin
               r_flags[1:0] <= ALUFlags[1:0];
            end
         end
      end
   end

   assign Flags = r_flags;
   assign condQ = r_condQ;

endmodule : cond_flag_unit
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control FSM of the multicycle ARM core. Sequences the
//               shared memory and ALU through fetch, decode and execute, and
//               gates all architectural writes by the instruction condition.
// Ports       : clk, reset                 - clock, sync active-high reset
//               Cond, Op, Funct, Rd        - instruction register fields
//               ALUFlags                   - ALU NZCV of the current cycle
//               PCWrite, MemWrite,
//               IRWrite, RegWrite          - write enables
//               AdrSrc, ResultSrc, ALUSrcA,
//               ALUSrcB, ALUControl        - datapath mux / ALU controls
//               ImmSrc, RegSrc             - decode-only controls
//               Flags, State               - debug visibility
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   input  logic [3:0] ALUFlags,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc,
   output logic       RegWrite,
   output logic [3:0] Flags,
   output logic [3:0] State
);

   state_t     r_state;
   state_t     w_nextState;

   logic       w_adrSrc;
   logic       w_irWrite;
   logic [1:0] w_resultSrc;
   logic [1:0] w_aluControl;
   logic       w_aluSrcA;
   logic [1:0] w_aluSrcB;
   logic       w_regW;
   logic       w_memW;
   logic       w_branch;
   logic       w_fetch;
   logic       w_latchCond;
   logic       w_execCycle;
   logic       w_condQ;
   logic [3:0] w_cmd;

   assign w_cmd = Funct[4:1];

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
      end else begin
         r_state <= w_nextState;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and raw per-state controls (before reset / condition gating)
   // ------------------------------------------------------------------------
   always_comb begin
      w_nextState  = FETCH;
      w_adrSrc     = 1'b0;
      w_irWrite    = 1'b0;
      w_resultSrc  = c_RES_ALUOUT;
      w_aluControl = c_ALU_ADD;
      w_aluSrcA    = 1'b0;
      w_aluSrcB    = c_SRCB_REG;
      w_regW       = 1'b0;
      w_memW       = 1'b0;
      w_branch     = 1'b0;
      w_fetch      = 1'b0;
      w_latchCond  = 1'b0;
      w_execCycle  = 1'b0;

      case (r_state)
         FETCH: begin
            w_irWrite   = 1'b1;
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = c_SRCB_FOUR;
            w_resultSrc = c_RES_ALU;
            w_fetch     = 1'b1;
            w_nextState = DECODE;
         end
         DECODE: begin
            // Second PC+4 on the ALU gives PC+8, which the datapath reads as R15.
            w_aluSrcA   = 1'b1;
            w_aluSrcB   = c_SRCB_FOUR;
            w_resultSrc = c_RES_ALU;
            w_latchCond = 1'b1;
            case (Op)
               c_OP_MEM: w_nextState = MEMADR;
               c_OP_DP:  w_nextState = Funct[5] ? EXECI : EXECR;
               c_OP_BR:  w_nextState = BRANCH;
               default:  w_nextState = FETCH;   // Op=11 retires as a NOP
            endcase
         end
         MEMADR: begin
            w_aluSrcB   = c_SRCB_IMM;
            w_nextState = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            w_adrSrc    = 1'b1;
            w_nextState = MEMWB;
         end
         MEMWB: begin
            w_resultSrc = c_RES_DATA;
            w_regW      = 1'b1;
            w_nextState = FETCH;
         end
         MEMWR: begin
            w_adrSrc    = 1'b1;
            w_memW      = 1'b1;
            w_nextState = FETCH;
         end
         EXECR: begin
            w_aluSrcB    = c_SRCB_REG;
            w_aluControl = aluOp(w_cmd);
            w_execCycle  = 1'b1;
            w_nextState  = ALUWB;
         end
         EXECI: begin
            w_aluSrcB    = c_SRCB_IMM;
            w_aluControl = aluOp(w_cmd);
            w_execCycle  = 1'b1;
            w_nextState  = ALUWB;
         end
         ALUWB: begin
            w_resultSrc = c_RES_ALUOUT;
            w_regW      = cmdWritesReg(w_cmd);
            w_nextState = FETCH;
         end
         BRANCH: begin
            w_aluSrcB   = c_SRCB_IMM;
            w_resultSrc = c_RES_ALU;
            w_branch    = 1'b1;
            w_nextState = FETCH;
         end
         default: begin
            w_nextState = FETCH;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output stage: reset forces all enables low and shows FETCH mux values,
   // so an instruction interrupted by reset cannot complete a write.
   // ------------------------------------------------------------------------
   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = c_RES_ALU;
      ALUControl = c_ALU_ADD;
      ALUSrcA    = 1'b1;
      ALUSrcB    = c_SRCB_FOUR;
      if (!reset) begin
         PCWrite    = w_fetch | (w_branch & w_condQ) |
                      (w_regW & (Rd == 4'd15) & w_condQ);
         IRWrite    = w_irWrite;
         RegWrite   = w_regW & w_condQ;
         MemWrite   = w_memW & w_condQ;
         AdrSrc     = w_adrSrc;
         ResultSrc  = w_resultSrc;
         ALUControl = w_aluControl;
         ALUSrcA    = w_aluSrcA;
         ALUSrcB    = w_aluSrcB;
      end
   end

   assign ImmSrc    = Op;
   assign RegSrc[0] = (Op == c_OP_BR);
   assign RegSrc[1] = (Op == c_OP_MEM);
   assign State     = r_state;

   // ------------------------------------------------------------------------
   // Flags and condition latch
   // ------------------------------------------------------------------------
   cond_flag_unit #(
      .RESET_FLAGS (RESET_FLAGS)
   ) u_cond_flag_unit (
      .clk       (clk),
      .reset     (reset),
      .Cond      (Cond),
      .ALUFlags  (ALUFlags),
      .latchCond (w_latchCond),
      .execCycle (w_execCycle),
      .sBit      (Funct[0]),
      .cmd       (w_cmd),
      .Flags     (Flags),
      .condQ     (w_condQ)
   );

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed scoreboard bench for multicycle_controller. Each
//               stimulus cycle pushes its hand-computed output vector; a
//               monitor on the falling edge pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] Cond;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic [3:0] ALUFlags;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
   logic [1:0] ResultSrc, ALUControl, ALUSrcB, ImmSrc, RegSrc;
   logic [3:0] Flags, State;

   always #5 clk = ~clk;

   multicycle_controller #(
      .RESET_FLAGS (4'b0000)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .ResultSrc  (ResultSrc),
      .ALUControl (ALUControl),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .RegWrite   (RegWrite),
      .Flags      (Flags),
      .State      (State)
   );

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] fl;
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic [1:0] res;
      logic [1:0] alu;
      logic       sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic [1:0] rsrc;
      logic       rw;
   } out_t;

   typedef struct {
      out_t  v;
      string tag;
   } exp_t;

   exp_t sbq[$];
   int   nChecks = 0;
   int   nFails  = 0;
   out_t w_act;

   assign w_act = {State, Flags, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                   ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite};

   // Monitor: one expectation per cycle, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         nChecks++;
         if (w_act !== e.v) begin
            nFails++;
            $display("FAIL %s: actual st=%0d fl=%b pcw=%b adr=%b mw=%b irw=%b res=%b alu=%b sa=%b sb=%b imm=%b rsrc=%b rw=%b | required st=%0d fl=%b pcw=%b adr=%b mw=%b irw=%b res=%b alu=%b sa=%b sb=%b imm=%b rsrc=%b rw=%b",
                     e.tag, w_act.st, w_act.fl, w_act.pcw, w_act.adr, w_act.mw, w_act.irw,
                     w_act.res, w_act.alu, w_act.sa, w_act.sb, w_act.imm, w_act.rsrc, w_act.rw,
                     e.v.st, e.v.fl, e.v.pcw, e.v.adr, e.v.mw, e.v.irw,
                     e.v.res, e.v.alu, e.v.sa, e.v.sb, e.v.imm, e.v.rsrc, e.v.rw);
         end
      end
   end

   task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                        input logic [3:0] r, input logic [3:0] af);
      Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = af;
   endtask

   // Drive one cycle (called just after a rising edge) and queue its outputs.
   task automatic cyc(input string tag, input logic rs, input logic [3:0] st,
                      input logic [3:0] fl, input logic pcw, input logic adr,
                      input logic mw, input logic irw, input logic [1:0] res,
                      input logic [1:0] alu, input logic sa, input logic [1:0] sb,
                      input logic rw);
      exp_t e;
      reset    = rs;
      e.v.st   = st;   e.v.fl  = fl;  e.v.pcw = pcw; e.v.adr = adr;
      e.v.mw   = mw;   e.v.irw = irw; e.v.res = res; e.v.alu = alu;
      e.v.sa   = sa;   e.v.sb  = sb;  e.v.rw  = rw;
      e.v.imm  = Op;
      e.v.rsrc = {(Op == 2'b01), (Op == 2'b10)};
      e.tag    = tag;
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic fetchC(input string tag, input logic [3:0] fl);
      cyc(tag, 1'b0, 4'd0, fl, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 2'b10, 1'b0);
   endtask

   task automatic decodeC(input string tag, input logic [3:0] fl);
      cyc(tag, 1'b0, 4'd1, fl, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b1, 2'b10, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'h0);          // ADD R1,R2,R3
      @(posedge clk);
      #1;
      cyc("reset_hold", 1'b1, 4'd0, 4'h0, 0,0,0,0, 2'b10, 2'b00, 1, 2'b10, 0);

      // ADD: 0,1,6,8 ; write only in ALUWB
      fetchC("add_fetch", 4'h0);
      decodeC("add_decode", 4'h0);
      cyc("add_execr", 0, 4'd6, 4'h0, 0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0);
      cyc("add_aluwb", 0, 4'd8, 4'h0, 0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 1);

      // SUBS R2 with ALUFlags=0100 -> Flags=0100
      instr(4'hE, 2'b00, 6'b000101, 4'd2, 4'b0100);
      fetchC("subs_fetch", 4'h0);
      decodeC("subs_decode", 4'h0);
      cyc("subs_execr", 0, 4'd6, 4'h0, 0,0,0,0, 2'b00, 2'b01, 0, 2'b00, 0);
      cyc("subs_aluwb", 0, 4'd8, 4'b0100, 0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 1);

      // BEQ taken (Z=1)
      instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'h0);
      fetchC("beq_fetch", 4'b0100);
      decodeC("beq_decode", 4'b0100);
      cyc("beq_branch", 0, 4'd9, 4'b0100, 1,0,0,0, 2'b10, 2'b00, 0, 2'b01, 0);

      // BNE not taken (Z=1)
      instr(4'h1, 2'b10, 6'b100000, 4'd0, 4'h0);
      fetchC("bne_fetch", 4'b0100);
      decodeC("bne_decode", 4'b0100);
      cyc("bne_branch", 0, 4'd9, 4'b0100, 0,0,0,0, 2'b10, 2'b00, 0, 2'b01, 0);

      // LDR R4: 0,1,2,3,4
      instr(4'hE, 2'b01, 6'b011001, 4'd4, 4'h0);
      fetchC("ldr_fetch", 4'b0100);
      decodeC("ldr_decode", 4'b0100);
      cyc("ldr_memadr", 0, 4'd2, 4'b0100, 0,0,0,0, 2'b00, 2'b00, 0, 2'b01, 0);
      cyc("ldr_memrd",  0, 4'd3, 4'b0100, 0,1,0,0, 2'b00, 2'b00, 0, 2'b00, 0);
      cyc("ldr_memwb",  0, 4'd4, 4'b0100, 0,0,0,0, 2'b01, 2'b00, 0, 2'b00, 1);

      // STR R4: MemWrite only in MEMWR
      instr(4'hE, 2'b01, 6'b011000, 4'd4, 4'h0);
      fetchC("str_fetch", 4'b0100);
      decodeC("str_decode", 4'b0100);
      cyc("str_memadr", 0, 4'd2, 4'b0100, 0,0,0,0, 2'b00, 2'b00, 0, 2'b01, 0);
      cyc("str_memwr",  0, 4'd5, 4'b0100, 0,1,1,0, 2'b00, 2'b00, 0, 2'b00, 0);

      // CMP with ALUFlags=0011 -> no reg write, Flags=0011
      instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0011);
      fetchC("cmp_fetch", 4'b0100);
      decodeC("cmp_decode", 4'b0100);
      cyc("cmp_execr", 0, 4'd6, 4'b0100, 0,0,0,0, 2'b00, 2'b01, 0, 2'b00, 0);
      cyc("cmp_aluwb", 0, 4'd8, 4'b0011, 0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0);

      // ANDS immediate with ALUFlags=1000 -> NZ loaded, CV held: 1011
      instr(4'hE, 2'b00, 6'b100001, 4'd5, 4'b1000);
      fetchC("ands_fetch", 4'b0011);
      decodeC("ands_decode", 4'b0011);
      cyc("ands_execi", 0, 4'd7, 4'b0011, 0,0,0,0, 2'b00, 2'b10, 0, 2'b01, 0);
      cyc("ands_aluwb", 0, 4'd8, 4'b1011, 0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 1);

      // ORR R15 immediate -> PCWrite in ALUWB
      instr(4'hE, 2'b00, 6'b111000, 4'd15, 4'h0);
      fetchC("orr15_fetch", 4'b1011);
      decodeC("orr15_decode", 4'b1011);
      cyc("orr15_execi", 0, 4'd7, 4'b1011, 0,0,0,0, 2'b00, 2'b11, 0, 2'b01, 0);
      cyc("orr15_aluwb", 0, 4'd8, 4'b1011, 1,0,0,0, 2'b00, 2'b00, 0, 2'b00, 1);

      // SUBSEQ R15 with Z=0: condition false, no writes, flags held
      instr(4'h0, 2'b00, 6'b000101, 4'd15, 4'b0100);
      fetchC("subseq_fetch", 4'b1011);
      decodeC("subseq_decode", 4'b1011);
      cyc("subseq_execr", 0, 4'd6, 4'b1011, 0,0,0,0, 2'b00, 2'b01, 0, 2'b00, 0);
      cyc("subseq_aluwb", 0, 4'd8, 4'b1011, 0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0);

      // Unsupported cmd (EOR, S=1): ALU ADD, no reg write, no flag write
      instr(4'hE, 2'b00, 6'b000011, 4'd6, 4'b0100);
      fetchC("eors_fetch", 4'b1011);
      decodeC("eors_decode", 4'b1011);
      cyc("eors_execr", 0, 4'd6, 4'b1011, 0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0);
      cyc("eors_aluwb", 0, 4'd8, 4'b1011, 0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0);

      // STREQ with Z=0: same latency, no MemWrite
      instr(4'h0, 2'b01, 6'b011000, 4'd4, 4'h0);
      fetchC("streq_fetch", 4'b1011);
      decodeC("streq_decode", 4'b1011);
      cyc("streq_memadr", 0, 4'd2, 4'b1011, 0,0,0,0, 2'b00, 2'b00, 0, 2'b01, 0);
      cyc("streq_memwr",  0, 4'd5, 4'b1011, 0,1,0,0, 2'b00, 2'b00, 0, 2'b00, 0);

      // Op=11 retires as NOP after DECODE
      instr(4'hE, 2'b11, 6'b000000, 4'd0, 4'h0);
      fetchC("nop_fetch", 4'b1011);
      decodeC("nop_decode", 4'b1011);

      // STR interrupted by reset in MEMWR
      instr(4'hE, 2'b01, 6'b011000, 4'd4, 4'h0);
      fetchC("strrst_fetch", 4'b1011);
      decodeC("strrst_decode", 4'b1011);
      cyc("strrst_memadr", 0, 4'd2, 4'b1011, 0,0,0,0, 2'b00, 2'b00, 0, 2'b01, 0);
      cyc("strrst_memwr",  1, 4'd5, 4'b1011, 0,0,0,0, 2'b10, 2'b00, 1, 2'b10, 0);
      fetchC("post_rst_fetch", 4'h0);
      decodeC("post_rst_decode", 4'h0);

      @(negedge clk);
      #1;
      nChecks++;
      if (sbq.size() != 0) begin
         nFails++;
         $display("FAIL scoreboard_drain: actual %0d entries left, required 0", sbq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule : tb_multicycle_controller
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle variant of the ARM core; shares one memory (instruction + data) and one ALU across fetch, PC increment and execute.
- Sits beside the datapath and sequences it.
- Decodes Op/Funct/Rd/Cond from the instruction register.
- Holds the architectural NZCV flags and gates all write enables by the condition result.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Cond  in  4  instruction bits [31:28].
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20]: I, cmd[3:0], S/L.
- Rd  in  4  instruction bits [15:12].
- ALUFlags  in  4  ALU {N,Z,C,V} of the current cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address mux: 0 = PC, 1 = ALU result register.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  instruction register enable.
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALU direct.
- ALUControl  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- ALUSrcA  out  1  ALU A input: 0 = register A, 1 = PC.
- ALUSrcB  out  2  ALU B input: 00 = register, 01 = ExtImm, 10 = constant 4.
- ImmSrc  out  2  immediate extend select.
- RegSrc  out  2  register-file read-address muxes.
- RegWrite  out  1  register-file write enable.
- Flags  out  4  registered NZCV, for debug.
- State  out  4  current FSM state, for debug.

Behaviour:
- State encoding (4-bit):
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9.
  - Codes 10–15 are illegal and go to FETCH on the next edge.
- Reset:
  - On an edge with reset=1: State := FETCH, Flags := RESET_FLAGS, cond_q := 0.
  - While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Mux outputs take their FETCH values.
  - Reset asserted mid-instruction abandons that instruction. No partial write completes after the reset edge.
- Per-state outputs. Any unlisted mux output is 00/0; any unlisted enable is 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALU ADD, ResultSrc=10 (PC+8 is available as R15). Latch cond_q := CondEx(Cond, Flags). Next state by Op:
    - Op=01 → MEMADR.
    - Op=00 with Funct[5]=0 → EXECR.
    - Op=00 with Funct[5]=1 → EXECI.
    - Op=10 → BRANCH.
    - Op=11 → FETCH (executes as a NOP).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALU ADD. Next MEMRD if Funct[0]=1, else MEMWR.
  - MEMRD: AdrSrc=1. Next MEMWB.
  - MEMWB: ResultSrc=01, RegW. Next FETCH.
  - MEMWR: AdrSrc=1, MemW. Next FETCH.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALU op from Funct[4:1]. Next ALUWB.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALU op from Funct[4:1]. Next ALUWB.
  - ALUWB: ResultSrc=00, RegW unless the instruction is CMP. Next FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALU ADD, ResultSrc=10, Branch. Next FETCH.
- ALU decode in EXECR/EXECI, from Funct[4:1]:
  - 0100 → ADD (00); 0010 → SUB (01); 0000 → AND (10); 1100 → ORR (11).
  - 1010 = CMP → SUB (01), with no register write.
  - Any other value → ADD (00), with no register write and no flag write.
- Write gating:
  - RegWrite = RegW & cond_q.
  - MemWrite = MemW & cond_q.
  - PCWrite = FETCH | (Branch & cond_q) | (RegW & Rd==15 & cond_q).
- Flag update:
  - Happens on the edge leaving EXECR/EXECI, only if cond_q=1 and Funct[0]=1 (S bit).
  - N,Z are always loaded from ALUFlags.
  - C,V are loaded only for ADD/SUB/CMP; they hold for AND/ORR.
  - Flags do not change in any other state.
- Condition evaluation uses Flags (registered), never ALUFlags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) = 1; 1111 = 1.
- Combinational from the instruction fields:
  - ImmSrc = Op.
  - RegSrc[0] = (Op==10).
  - RegSrc[1] = (Op==01).
- Latency in cycles: branch 3, data-processing 4, STR 4, LDR 5. Condition-false instructions take the same number of cycles but perform no writes.

Decomposition:
- Shared package holds:
  - state codes;
  - ALUControl codes;
  - ResultSrc / ALUSrcB codes;
  - Op codes;
  - Cond codes (EQ..AL);
  - cmd codes (ADD, SUB, AND, ORR, CMP).
- One sub-module, cond_flag_unit, contains the NZCV registers, the S/C-V write logic and the CondEx function. The FSM and output decode stay in multicycle_controller.

Test Plan:
- Reset held for 2 cycles then released, with IR = ADD R1,R2,R3 (Op=00, Funct=001000, Cond=1110) → State goes 0,1,6,8,0. RegWrite=1 only in ALUWB. Flags stay 0000.
- SUBS with ALUFlags=0100 presented in EXECR, followed by BEQ (Op=10, Cond=0000) → Flags=0100. BRANCH asserts PCWrite=1 and ResultSrc=10.
- BNE with Flags Z=1 → BRANCH has PCWrite=0. The next FETCH still has PCWrite=1 and IRWrite=1.
- LDR (Op=01, Funct[0]=1) → states 0,1,2,3,4. AdrSrc=1 in MEMRD. RegWrite=1 with ResultSrc=01 in MEMWB. STR (Funct[0]=0) → MemWrite=1 only in MEMWR.
- CMP with ALUFlags=0011 presented in EXECR → RegWrite=0 in ALUWB. Flags=0011. ANDS with ALUFlags=1000 afterwards → Flags=1011.
- Reset asserted during MEMWR → MemWrite=0 in that cycle. State=FETCH on the next edge. Flags=RESET_FLAGS.
